// File: rtl/div_nr_seq.sv
// Iterative non-restoring divider (signed/unsigned) with start/busy/done handshake.
// Optional abort input is enabled by defining DIV_ABORT_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; operands and signs latched on accept
// RUN    | one non-restoring step per cycle, WIDTH steps in total
// FIX    | remainder correction, sign application, result register
// DONE   | done pulse, results valid; returns to IDLE
module div_nr_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
`ifdef DIV_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dsr_mag;
   logic             sign_q;
   logic             sign_r;
   logic             zero_div;

   logic             abort_hit;
   logic             last_step;
   logic             divisor_zero;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   dsr_ext;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_step;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] quo_out;
   logic [WIDTH-1:0] rem_out;

`ifdef DIV_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign last_step    = (cnt == CNT_W'(WIDTH - 1));
   assign divisor_zero = (divisor == '0);

   // |MIN| still fits because the magnitude is treated as unsigned
   assign dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   assign dsr_ext   = {1'b0, dsr_mag};
   assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
   assign rem_step  = rem[WIDTH] ? (rem_shift + dsr_ext) : (rem_shift - dsr_ext);

   // corrected remainder is below the divisor, so the low WIDTH bits carry it all
   assign rem_fix = rem[WIDTH] ? (rem[WIDTH-1:0] + dsr_mag) : rem[WIDTH-1:0];
   assign quo_out = sign_q ? -quo : quo;
   assign rem_out = sign_r ? -rem_fix : rem_fix;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = divisor_zero ? S_FIX : S_RUN;
            end
         end
         S_RUN: begin
            if (abort_hit) begin
               state_nxt = S_IDLE;
            end else if (last_step) begin
               state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            state_nxt = abort_hit ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_RUN:   busy = 1'b1;
         S_FIX:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         rem         <= '0;
         quo         <= '0;
         dsr_mag     <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         zero_div    <= 1'b0;
         q           <= '0;
         r           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  cnt         <= '0;
                  dsr_mag     <= dvs_mag;
                  div_by_zero <= 1'b0;
                  // zero divisor preloads all-ones / raw dividend so FIX passes them straight through
                  if (divisor_zero) begin
                     quo      <= '1;
                     rem      <= {1'b0, dividend};
                     sign_q   <= 1'b0;
                     sign_r   <= 1'b0;
                     zero_div <= 1'b1;
                  end else begin
                     quo      <= dvd_mag;
                     rem      <= '0;
                     sign_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     sign_r   <= is_signed & dividend[WIDTH-1];
                     zero_div <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               rem <= rem_step;
               quo <= {quo[WIDTH-2:0], ~rem_step[WIDTH]};
               cnt <= cnt + 1'b1;
            end
            S_FIX: begin
               if (!abort_hit) begin
                  q           <= quo_out;
                  r           <= rem_out;
                  div_by_zero <= zero_div;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
